// File: rtl/rcvr_xmit_if.sv
`default_nettype none
// ============================================================================
// Module      : rcvr_xmit_if
// Description : Byte load handshake and serial output bundle of rcvr_xmit.
// Revision    : 1.0 - initial release
// ============================================================================
interface rcvr_xmit_if;
    logic       load;
    logic [7:0] data_in;
    logic       ready;
    logic       busy;
    logic       overrun;
    logic       data_out;

    // Byte source side
    modport master (
        output load,
        output data_in,
        input  ready,
        input  busy,
        input  overrun,
        input  data_out
    );

    // Transmitter side
    modport slave (
        input  load,
        input  data_in,
        output ready,
        output busy,
        output overrun,
        output data_out
    );
endinterface
`default_nettype wire

// File: rtl/rcvr_xmit.sv
`default_nettype none
// ============================================================================
// Module      : rcvr_xmit
// Description : Bit-serial frame transmitter, {MATCH, byte} MSB first with a
//               one-byte holding register and optional idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module rcvr_xmit #(
    parameter logic [7:0] MATCH = 8'hA5,
    parameter int         GAP   = 0
) (
    input  wire logic   clock,
    input  wire logic   reset,
    rcvr_xmit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam bit         c_has_gap  = (GAP != 0);
    localparam logic [3:0] c_gap_last = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    state_t     r_state, w_nxt_state;
    logic [3:0] r_cnt, w_nxt_cnt;
    logic [7:0] r_shift, w_nxt_shift;
    logic [7:0] r_hold, w_nxt_hold;
    logic       r_ready, w_nxt_ready;      // 1 = holding register empty
    logic       r_busy, w_nxt_busy;
    logic       r_overrun, w_nxt_overrun;
    logic       r_data_out, w_nxt_data_out;

    logic       w_accept;
    logic       w_decide;
    logic       w_launch_in;
    logic [2:0] w_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_shift    <= 8'd0;
            r_hold     <= 8'd0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_data_out <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_shift    <= w_nxt_shift;
            r_hold     <= w_nxt_hold;
            r_ready    <= w_nxt_ready;
            r_busy     <= w_nxt_busy;
            r_overrun  <= w_nxt_overrun;
            r_data_out <= w_nxt_data_out;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_cnt      = r_cnt;
        w_nxt_shift    = r_shift;
        w_nxt_hold     = r_hold;
        w_nxt_ready    = r_ready;
        w_nxt_busy     = r_busy;
        w_nxt_overrun  = r_overrun;
        w_nxt_data_out = r_data_out;
        w_decide       = 1'b0;
        w_launch_in    = 1'b0;
        w_accept       = bus.load & r_ready;
        // data_out is registered, so each cycle loads the bit that follows the current one
        w_idx          = 3'd6 - r_cnt[2:0];

        case (r_state)
            ST_IDLE: w_decide = 1'b1;
            ST_HEAD: begin
                if (r_cnt == 4'd7) begin
                    w_nxt_state    = ST_BODY;
                    w_nxt_cnt      = 4'd0;
                    w_nxt_data_out = r_shift[7];
                end else begin
                    w_nxt_cnt      = r_cnt + 4'd1;
                    w_nxt_data_out = MATCH[w_idx];
                end
            end
            ST_BODY: begin
                if (r_cnt == 4'd7) begin
                    if (c_has_gap) begin
                        w_nxt_state    = ST_GAP;
                        w_nxt_cnt      = 4'd0;
                        w_nxt_data_out = 1'b0;
                    end else begin
                        w_decide = 1'b1;
                    end
                end else begin
                    w_nxt_cnt      = r_cnt + 4'd1;
                    w_nxt_data_out = r_shift[w_idx];
                end
            end
            ST_GAP: begin
                if (r_cnt == c_gap_last) w_decide = 1'b1;
                else                     w_nxt_cnt = r_cnt + 4'd1;
            end
            default: w_nxt_state = ST_IDLE;
        endcase

        // Held byte has priority; otherwise a load on this edge starts the next frame directly
        if (w_decide) begin
            if (!r_ready || w_accept) begin
                w_nxt_shift    = r_ready ? bus.data_in : r_hold;
                w_launch_in    = r_ready;
                w_nxt_ready    = 1'b1;
                w_nxt_state    = ST_HEAD;
                w_nxt_cnt      = 4'd0;
                w_nxt_busy     = 1'b1;
                w_nxt_data_out = MATCH[7];
            end else begin
                w_nxt_state    = ST_IDLE;
                w_nxt_cnt      = 4'd0;
                w_nxt_busy     = 1'b0;
                w_nxt_data_out = 1'b0;
            end
        end

        if (w_accept) begin
            w_nxt_overrun = 1'b0;
            if (!w_launch_in) begin
                w_nxt_hold  = bus.data_in;
                w_nxt_ready = 1'b0;
            end
        end else if (bus.load) begin
            w_nxt_overrun = 1'b1;
        end
    end

    assign bus.ready    = r_ready;
    assign bus.busy     = r_busy;
    assign bus.overrun  = r_overrun;
    assign bus.data_out = r_data_out;

endmodule
`default_nettype wire
